quadrature_encoder: RTL and testbench

//   Decodes a two-channel incremental (quadrature) motor encoder into a signed position count.

---
 rtl/quadrature_encoder.sv | 103 ++++++++++
 tb/tb_quadrature_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_encoder.sv
// Quadrature encoder decoder: synchronises and debounces A/B, decodes Gray-code steps
// into a signed position count and a direction flag that drops to "stopped" after idling.
module quadrature_encoder #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ENCA_raw,
    input  logic        ENCB_raw,
    output logic [1:0]  DIR,
    output logic [31:0] position
);

    localparam int IDLE_MAX = CLK_FREQ / 10;
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_MAX);
    localparam logic [IW-1:0] IDLE_PRE = IW'(IDLE_MAX - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync1, sync2, filt, prev;
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    settle;
    logic          primed;
    logic [IW-1:0] idle;
    logic [1:0]    delta;
    logic          step_cw, step_ccw, stable;

    // Gray {A,B} to phase index: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] phase(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // bit 1 carries channel A, bit 0 channel B throughout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {ENCA_raw, ENCB_raw};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priming waits until the synchroniser reflects the pins and the filter agrees with it,
    // so a non-zero resting state after reset is loaded rather than counted.
    always_comb begin
        delta    = phase(filt) - phase(prev);
        step_cw  = primed && (delta == 2'd1);
        step_ccw = primed && (delta == 2'd3);
        stable   = (settle == 2'd3) && (sync2 == filt) &&
                   (db_cnt[0] == '0) && (db_cnt[1] == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle   <= 2'd0;
            primed   <= 1'b0;
            prev     <= 2'b00;
            idle     <= '0;
            DIR      <= 2'b00;
            position <= 32'd0;
        end else begin
            if (settle != 2'd3) settle <= settle + 2'd1;
            if (primed) begin
                prev <= filt;
            end else if (stable) begin
                prev   <= filt;
                primed <= 1'b1;
            end

            // Illegal double-bit jumps fall through to the idle path on purpose
            if (step_cw || step_ccw) begin
                idle     <= '0;
                position <= step_cw ? position + 32'd1 : position - 32'd1;
                DIR      <= step_cw ? 2'b01 : 2'b10;
            end else if (idle != IDLE_LIM) begin
                idle <= idle + 1'b1;
                if (idle == IDLE_PRE) DIR <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_encoder.sv
// Randomised bench for quadrature_encoder: a phase-index encoder model drives the pins
// (with optional contact bounce) and tracks the expected count and direction.
module tb_quadrature_encoder;

    localparam int CLK_FREQ = 10_000;
    localparam int DB       = 8;
    localparam int IDLE_MAX = CLK_FREQ / 10;
    localparam int LAT      = DB + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enca = 1'b0, encb = 1'b0;
    logic [1:0]  dir_o;
    logic [31:0] pos_o;

    int          checks = 0, failures = 0;
    int          ph = 0;
    int          exp_pos = 0;
    logic [1:0]  exp_dir = 2'b00;

    quadrature_encoder #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .ENCA_raw(enca), .ENCB_raw(encb),
        .DIR(dir_o), .position(pos_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [1:0] gray(input int q);
        case (q % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // d = +1 CW, -1 CCW, 2 illegal double-bit jump; waits the worst-case latency
    task automatic move(input int d, input bit bounce);
        logic [1:0] g_old, g_new;
        g_old = gray(ph);
        ph    = (ph + d + 4) % 4;
        g_new = gray(ph);
        if (bounce) begin
            repeat ($urandom_range(0, 3)) begin
                {enca, encb} = g_new;
                tick($urandom_range(1, DB - 3));
                {enca, encb} = g_old;
                tick($urandom_range(1, DB - 3));
            end
        end
        {enca, encb} = g_new;
        if (d == 1) begin
            exp_pos++;
            exp_dir = 2'b01;
        end else if (d == -1) begin
            exp_pos--;
            exp_dir = 2'b10;
        end
        tick(LAT);
    endtask

    task automatic test_reset;
        tick(3);
        checks++;
        if (pos_o !== 32'd0 || dir_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold: pos=%0d dir=%b expected pos=0 dir=00", pos_o, dir_o);
        end
        reset = 1'b0;
        tick(20);
        checks++;
        if (pos_o !== 32'd0 || dir_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: pos=%0d dir=%b expected pos=0 dir=00", pos_o, dir_o);
        end
    endtask

    task automatic test_cw;
        for (int i = 0; i < 10; i++) begin
            move(1, 0);
            checks++;
            if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
                failures++;
                $display("FAIL cw_step%0d: pos=%0d dir=%b expected pos=%0d dir=%b",
                         i, $signed(pos_o), dir_o, exp_pos, exp_dir);
            end
            tick(20);
        end
    endtask

    task automatic test_ccw;
        for (int i = 0; i < 15; i++) begin
            move(-1, 0);
            checks++;
            if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
                failures++;
                $display("FAIL ccw_step%0d: pos=%0d dir=%b expected pos=%0d dir=%b",
                         i, $signed(pos_o), dir_o, exp_pos, exp_dir);
            end
            tick(20);
        end
        checks++;
        if (pos_o !== 32'hFFFF_FFFB) begin
            failures++;
            $display("FAIL ccw_final: pos=%h expected FFFFFFFB", pos_o);
        end
    endtask

    task automatic test_pause_cw;
        tick(IDLE_MAX / 2);
        checks++;
        if (pos_o !== 32'(exp_pos) || dir_o !== 2'b10) begin
            failures++;
            $display("FAIL pause_before: pos=%0d dir=%b expected pos=%0d dir=10",
                     $signed(pos_o), dir_o, exp_pos);
        end
        for (int i = 0; i < 5; i++) begin
            move(1, 0);
            checks++;
            if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
                failures++;
                $display("FAIL cw2_step%0d: pos=%0d dir=%b expected pos=%0d dir=%b",
                         i, $signed(pos_o), dir_o, exp_pos, exp_dir);
            end
            tick(20);
        end
        tick(IDLE_MAX / 2);
        checks++;
        if (pos_o !== 32'd0 || dir_o !== 2'b01) begin
            failures++;
            $display("FAIL pause_after: pos=%0d dir=%b expected pos=0 dir=01", $signed(pos_o), dir_o);
        end
    endtask

    task automatic test_idle;
        int waited;
        ph = (ph + 3) % 4;
        {enca, encb} = gray(ph);
        exp_pos--;
        exp_dir = 2'b10;
        waited = 0;
        while (pos_o !== 32'(exp_pos) && waited < LAT + 2) begin
            tick(1);
            waited++;
        end
        checks++;
        if (pos_o !== 32'(exp_pos)) begin
            failures++;
            $display("FAIL idle_step: pos=%0d expected %0d within %0d cycles",
                     $signed(pos_o), exp_pos, LAT + 2);
        end
        tick(IDLE_MAX - 3);
        checks++;
        if (dir_o !== 2'b10) begin
            failures++;
            $display("FAIL idle_early: dir=%b expected 10 just before timeout", dir_o);
        end
        tick(5);
        exp_dir = 2'b00;
        checks++;
        if (dir_o !== 2'b00 || pos_o !== 32'(exp_pos)) begin
            failures++;
            $display("FAIL idle_timeout: pos=%0d dir=%b expected pos=%0d dir=00",
                     $signed(pos_o), dir_o, exp_pos);
        end
        for (int i = 0; i < 2; i++) begin
            move(1, 0);
            checks++;
            if (pos_o !== 32'(exp_pos) || dir_o !== 2'b01) begin
                failures++;
                $display("FAIL idle_wake%0d: pos=%0d dir=%b expected pos=%0d dir=01",
                         i, $signed(pos_o), dir_o, exp_pos);
            end
            tick(10);
        end
    endtask

    task automatic test_glitch;
        enca = ~enca;
        tick(3);
        enca = ~enca;
        tick(LAT + 8);
        checks++;
        if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
            failures++;
            $display("FAIL glitch: pos=%0d dir=%b expected pos=%0d dir=%b",
                     $signed(pos_o), dir_o, exp_pos, exp_dir);
        end
        move(2, 0);
        tick(8);
        checks++;
        if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
            failures++;
            $display("FAIL illegal_jump: pos=%0d dir=%b expected pos=%0d dir=%b",
                     $signed(pos_o), dir_o, exp_pos, exp_dir);
        end
        move(-1, 0);
        checks++;
        if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
            failures++;
            $display("FAIL after_illegal: pos=%0d dir=%b expected pos=%0d dir=%b",
                     $signed(pos_o), dir_o, exp_pos, exp_dir);
        end
    endtask

    task automatic test_random;
        int r, d;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 7);
            d = (r == 0) ? 2 : ((r < 4) ? 1 : -1);
            move(d, 1);
            checks++;
            if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
                failures++;
                $display("FAIL rand_step%0d(d=%0d): pos=%0d dir=%b expected pos=%0d dir=%b",
                         i, d, $signed(pos_o), dir_o, exp_pos, exp_dir);
            end
            tick($urandom_range(0, 30));
        end
    endtask

    task automatic test_prime_reset;
        #2 reset = 1'b1;
        ph = 2;
        {enca, encb} = gray(ph);
        exp_pos = 0;
        exp_dir = 2'b00;
        tick(3);
        reset = 1'b0;
        tick(40);
        checks++;
        if (pos_o !== 32'd0 || dir_o !== 2'b00) begin
            failures++;
            $display("FAIL prime_11: pos=%0d dir=%b expected pos=0 dir=00", $signed(pos_o), dir_o);
        end
        for (int i = 0; i < 3; i++) begin
            move(1, 1);
            checks++;
            if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
                failures++;
                $display("FAIL prime_step%0d: pos=%0d dir=%b expected pos=%0d dir=%b",
                         i, $signed(pos_o), dir_o, exp_pos, exp_dir);
            end
            tick(10);
        end
        ph = (ph + 1) % 4;
        {enca, encb} = gray(ph);
        tick(5);
        #2 reset = 1'b1;
        #1;
        exp_pos = 0;
        exp_dir = 2'b00;
        checks++;
        if (pos_o !== 32'd0 || dir_o !== 2'b00) begin
            failures++;
            $display("FAIL async_reset: pos=%0d dir=%b expected pos=0 dir=00", $signed(pos_o), dir_o);
        end
        tick(2);
        reset = 1'b0;
        tick(40);
        checks++;
        if (pos_o !== 32'd0 || dir_o !== 2'b00) begin
            failures++;
            $display("FAIL reprime: pos=%0d dir=%b expected pos=0 dir=00", $signed(pos_o), dir_o);
        end
        move(-1, 0);
        checks++;
        if (pos_o !== 32'(exp_pos) || dir_o !== exp_dir) begin
            failures++;
            $display("FAIL resume: pos=%0d dir=%b expected pos=%0d dir=%b",
                     $signed(pos_o), dir_o, exp_pos, exp_dir);
        end
    endtask

    initial begin
        test_reset();
        test_cw();
        test_ccw();
        test_pause_cw();
        test_idle();
        test_glitch();
        test_random();
        test_prime_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
